// File: rtl/axis_dac_softmute_formatter.sv
//------------------------------------------------------------------------------
// axis_dac_softmute_formatter
//
// Multi-channel DAC output stage. It takes an AXI-Stream of NUM_CH packed
// signed samples and adds a saturating per-channel offset. It then scales the
// result by a soft-mute gain that ramps on start, stop and underrun. Finally it
// emits offset-binary DAC codes (inverted magnitude bits, Red Pitaya format)
// together with a mute flag that is time-aligned with the codes.
//
// Ports
//   aclk           clock
//   areset         synchronous reset, active-high
//   enable         run request; low requests a ramp-down to mute
//   offset         NUM_CH x W signed offsets, sampled every cycle
//   s_axis_tdata   NUM_CH x W signed samples, channel 0 in the LSBs
//   s_axis_tvalid  sample valid
//   s_axis_tready  high in RAMP_UP and RUN
//   dac_code       NUM_CH x W formatted DAC codes
//   dac_mute       high while muted, aligned with dac_code
//   underrun_cnt   saturating count of underrun-triggered ramp-downs
//   state          IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_dac_softmute_formatter #(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int NUM_CH         = 2,
  parameter int GAIN_BITS      = 8,
  parameter int RAMP_STEP      = 16,
  parameter int UNDERRUN_HOLD  = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             enable,
  input  logic [NUM_CH*DAC_DATA_WIDTH-1:0] offset,
  input  logic [NUM_CH*DAC_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [NUM_CH*DAC_DATA_WIDTH-1:0] dac_code,
  output logic                             dac_mute,
  output logic [15:0]                      underrun_cnt,
  output logic [1:0]                       state
);

  localparam int DATA_W = DAC_DATA_WIDTH;
  localparam int COEF_W = GAIN_BITS + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SC_W   = (UNDERRUN_HOLD < 2) ? 1 : $clog2(UNDERRUN_HOLD + 1);

  localparam logic [COEF_W-1:0] GAIN_FULL   = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [COEF_W:0]   RAMP_STEP_W = (COEF_W + 1)'(RAMP_STEP);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RAMP_UP   = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_RAMP_DOWN = 2'd3;

  // Add in W+1 bits; a disagreement between the top two bits means overflow.
  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = (DATA_W + 1)'(a) + (DATA_W + 1)'(b);
    if (s[DATA_W] != s[DATA_W-1])
      sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = s[DATA_W-1:0];
  endfunction

  // Gain never exceeds 2^GAIN_BITS, so the floored product always fits in W bits.
  function automatic logic signed [DATA_W-1:0] apply_gain(
    input logic signed [DATA_W-1:0] x,
    input logic        [COEF_W-1:0] g
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(x) * PROD_W'($signed({1'b0, g}));
    p = p >>> GAIN_BITS;
    apply_gain = p[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] to_dac(input logic signed [DATA_W-1:0] x);
    to_dac = {x[DATA_W-1], ~x[DATA_W-2:0]};
  endfunction

  logic [COEF_W-1:0] gain;
  logic [COEF_W-1:0] gain_up;
  logic [COEF_W-1:0] gain_dn;
  logic [COEF_W:0]   up_sum;
  logic [SC_W-1:0]   starve;
  logic              starve_hit;
  logic              accept;

  logic signed [DATA_W-1:0] hold_p0 [NUM_CH];
  logic signed [DATA_W-1:0] sum_p1  [NUM_CH];
  logic signed [DATA_W-1:0] prod_p2 [NUM_CH];
  logic                     vld_p1;
  logic                     vld_p2;

  always_comb begin
    s_axis_tready = (state == S_RAMP_UP) || (state == S_RUN);
    accept        = s_axis_tvalid && s_axis_tready;
    // This cycle would be the UNDERRUN_HOLD-th consecutive starved one.
    starve_hit    = !s_axis_tvalid && (starve == SC_W'(UNDERRUN_HOLD - 1));
    up_sum        = {1'b0, gain} + RAMP_STEP_W;
    gain_up       = (up_sum >= {1'b0, GAIN_FULL}) ? GAIN_FULL : up_sum[COEF_W-1:0];
    gain_dn       = ({1'b0, gain} <= RAMP_STEP_W) ? '0 : gain - RAMP_STEP_W[COEF_W-1:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= S_IDLE;
      gain         <= '0;
      starve       <= '0;
      underrun_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          gain   <= '0;
          starve <= '0;
          if (enable && s_axis_tvalid)
            state <= S_RAMP_UP;
        end
        S_RAMP_UP, S_RUN: begin
          if (state == S_RAMP_UP)
            gain <= gain_up;
          starve <= s_axis_tvalid ? '0 : starve + SC_W'(1);
          // An underrun wins over a simultaneous disable so it is always counted.
          if (starve_hit) begin
            state <= S_RAMP_DOWN;
            if (underrun_cnt != 16'hFFFF)
              underrun_cnt <= underrun_cnt + 16'd1;
          end else if (!enable) begin
            state <= S_RAMP_DOWN;
          end else if ((state == S_RAMP_UP) && (gain_up == GAIN_FULL)) begin
            state <= S_RUN;
          end
        end
        default: begin
          gain <= gain_dn;
          if (gain_dn == '0) begin
            state  <= S_IDLE;
            starve <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hold_p0[c]                   <= '0;
        sum_p1[c]                    <= '0;
        prod_p2[c]                   <= '0;
        dac_code[c*DATA_W +: DATA_W] <= to_dac('0);
      end
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      dac_mute <= 1'b1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // Stage 0: hold register, frozen whenever no beat is accepted
        if (accept)
          hold_p0[c] <= s_axis_tdata[c*DATA_W +: DATA_W];
        // Stage 1: saturating offset
        sum_p1[c] <= sat_add(hold_p0[c], offset[c*DATA_W +: DATA_W]);
        // Stage 2: soft-mute gain, using the gain register as it stands now
        prod_p2[c] <= apply_gain(sum_p1[c], gain);
        // Stage 3: DAC code formatting
        dac_code[c*DATA_W +: DATA_W] <= to_dac(prod_p2[c]);
      end
      vld_p1   <= (state != S_IDLE);
      vld_p2   <= vld_p1;
      dac_mute <= !vld_p2;
    end
  end

endmodule

// File: doc/axis_dac_softmute_formatter.md
Name: axis_dac_softmute_formatter

Overview:
- Parametrised successor to the two-channel DAC output stage.
- Accepts an AXI-Stream of NUM_CH packed signed samples and applies a per-channel saturating offset.
- Applies a soft-mute gain ramp on start, stop and stream underrun, so the DAC never sees a step to or from zero.
- Emits Red Pitaya DAC-format codes plus a mute flag; sits between the lock-in output path and the DDR/ODDR pin driver.

Parameters:
- DAC_DATA_WIDTH, 14: sample and code width W per channel.
- NUM_CH, 2: number of channels packed in tdata; channel 0 is in the LSBs.
- GAIN_BITS, 8: fractional bits of the mute gain; full gain = 2^GAIN_BITS.
- RAMP_STEP, 16: gain increment/decrement per cycle during ramps; must be >= 1.
- UNDERRUN_HOLD, 4: consecutive cycles with tvalid low in RUN before ramp-down; must be >= 1.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- enable  in  1  run request; low requests ramp-down to mute.
- offset  in  NUM_CH*W  signed per-channel offsets, sampled every cycle.
- s_axis_tdata  in  NUM_CH*W  signed samples.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accepted when tvalid & tready.
- dac_code  out  NUM_CH*W  formatted DAC codes.
- dac_mute  out  1  high while muted, aligned with dac_code; drives the DAC reset pin.
- underrun_cnt  out  16  saturating count of underrun-triggered ramp-downs.
- state  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.

Behaviour:
- Reset (areset high at a clock edge): state IDLE, gain 0, hold regs 0, pipeline regs 0, dac_code = 0x1FFF per channel (formatted zero), dac_mute 1, underrun_cnt 0, starve counter 0. Reset mid-ramp or mid-run produces the same values at the next edge; no ramp is performed.
- s_axis_tready = 1 only in RAMP_UP and RUN. On tvalid & tready, the per-channel hold regs load tdata. Otherwise the hold regs keep the last sample.
- Pipeline, 3 stages, one cycle each:
  - S1: sum = hold + offset, computed in W+1 bits, clamped to [-2^(W-1), 2^(W-1)-1].
  - S2: prod = sum * gain, with gain unsigned GAIN_BITS+1 wide; result = prod >>> GAIN_BITS (arithmetic, floor). At full gain, result == sum exactly.
  - S3: code = {x[W-1], ~x[W-2:0]}.
- Latency: accepted beat to dac_code is 3 cycles. The gain used in S2 is the gain register value at S2 time.
- dac_mute = (state==IDLE) delayed 3 cycles, so it aligns with dac_code.
- FSM:
  - IDLE: gain 0. Go to RAMP_UP when enable & s_axis_tvalid.
  - RAMP_UP: gain = min(gain+RAMP_STEP, 2^GAIN_BITS). Go to RUN on the cycle gain reaches full. Go to RAMP_DOWN if enable is low or the starve counter reaches UNDERRUN_HOLD (underrun, counted).
  - RUN: starve counter increments each cycle tvalid is low and clears on tvalid. Reaching UNDERRUN_HOLD → RAMP_DOWN and underrun_cnt+1 (saturates at 0xFFFF). enable low → RAMP_DOWN, not counted. If both occur in the same cycle, the event counts as underrun.
  - RAMP_DOWN: gain = max(gain-RAMP_STEP, 0); go to IDLE when gain reaches 0. Hold regs are frozen; enable and tvalid are ignored until IDLE is reached.
- The starve counter clears on entry to IDLE.
- While starved but below UNDERRUN_HOLD, output repeats the held sample.

Test Plan:
- Reset, W=14, NUM_CH=2 → dac_code = 0x1FFF_1FFF (both channels), dac_mute=1, tready=0, state=0.
- Full-gain formatting: enable=1, tvalid=1, offset=0, samples 0x1FFF/0x2000/0x0000/0x3FFF → after ramp, codes 0x0000/0x3FFF/0x1FFF/0x2000 appear 3 cycles after acceptance.
- Offset saturation: sample 0x1F00 + offset 0x0200 → clamped 0x1FFF → code 0x0000. Sample 0x2000 + offset 0x3FFF (-1) → 0x2000 → code 0x3FFF.
- Ramp: constant sample 0x1000 from IDLE, RAMP_STEP=16 → gain 16,32,…,256 over 16 cycles. Pre-format outputs run 0x0100, 0x0200, … up to 0x1000; RUN is entered on the 16th cycle.
- Underrun: in RUN, tvalid low 3 cycles then high → no ramp and held sample repeated. tvalid low 4 cycles → RAMP_DOWN, underrun_cnt=1, tready=0, IDLE 16 cycles later, dac_mute=1 3 cycles after that.
- Disable and reset: enable low in RUN → ramp-down with underrun_cnt unchanged. areset pulsed mid-RAMP_UP → reset values on the next edge.
